// File: rtl/ser_tx_pkg.sv
// Shared types and default constants for the parametrised serial transmitter.
package ser_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    TX   = 2'd2
  } ser_tx_state_t;

  localparam int         DEF_PATTERN_W = 4;
  localparam logic [3:0] DEF_PATTERN   = 4'b1101;
  localparam int         DEF_LEN_W     = 4;

endpackage

// File: rtl/bit_counter.sv
// W-bit up/down counter with synchronous load (priority over enable).
// tc flags that the next enabled step lands on the terminal value:
// 0 when counting down, all-ones when counting up.
module bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] value,
  output logic         tc
);

  // Counter register: load wins over a count step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      value <= '0;
    else if (load) value <= load_val;
    else if (en)   value <= up ? value + 1'b1 : value - 1'b1;
  end

  assign tc = up ? (value == ({W{1'b1}} - 1'b1)) : (value == W'(1));

endmodule

// File: rtl/param_serial_transmitter.sv
// Start-pattern detector + length-framed serial forwarder. All state moves
// only on clk_en strobes; the valid/done pulses drop on every clk edge.
module param_serial_transmitter
  import ser_tx_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int                   LEN_W     = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [LEN_W-1:0] count
);

  localparam int IDX_W = $clog2(LEN_W + 1);

  ser_tx_state_t        state;
  logic [PATTERN_W-1:0] history;
  logic [PATTERN_W-1:0] history_next;
  logic [LEN_W-1:0]     acc;
  logic [LEN_W-1:0]     acc_next;
  logic [LEN_W-1:0]     remaining;
  logic [IDX_W-1:0]     index;
  logic                 match;
  logic                 len_last;
  logic                 tx_step;
  logic                 rem_tc;
  logic                 count_tc;
  logic                 tx_last;

  // Newest bit enters at the LSB; the size cast drops the oldest bit.
  assign history_next = PATTERN_W'({history, ser_in});
  assign acc_next     = LEN_W'({acc, ser_in});

  assign match    = clk_en && (state == IDLE) && (history_next == PATTERN);
  assign len_last = clk_en && (state == LEN) && (index == IDX_W'(LEN_W - 1));
  // Never decrement below zero even if the state were somehow inconsistent.
  assign tx_step  = clk_en && (state == TX) && (remaining != '0);
  // count_tc can only fire together with rem_tc (L <= 2^LEN_W-1); it is a
  // second guard that keeps count from ever wrapping.
  assign tx_last  = rem_tc || count_tc;

  bit_counter #(.W(LEN_W)) u_remaining (
    .clk      (clk),
    .rst      (rst),
    .load     (len_last && (acc_next != '0)),
    .load_val (acc_next),
    .en       (tx_step),
    .up       (1'b0),
    .value    (remaining),
    .tc       (rem_tc)
  );

  bit_counter #(.W(LEN_W)) u_count (
    .clk      (clk),
    .rst      (rst),
    .load     (match),
    .load_val ('0),
    .en       (tx_step),
    .up       (1'b1),
    .value    (count),
    .tc       (count_tc)
  );

  // Frame FSM with registered outputs; history clears on every return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      history       <= '0;
      acc           <= '0;
      index         <= '0;
      ser_out       <= 1'b0;
      ser_out_valid <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ser_out_valid <= 1'b0;
      frame_done    <= 1'b0;
      if (clk_en) begin
        unique case (state)
          IDLE: begin
            history <= history_next;
            if (match) begin
              state <= LEN;
              acc   <= '0;
              index <= '0;
              busy  <= 1'b1;
            end
          end
          LEN: begin
            acc   <= acc_next;
            index <= index + 1'b1;
            if (len_last) begin
              if (acc_next == '0) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                history    <= '0;
                state      <= IDLE;
              end else begin
                state <= TX;
              end
            end
          end
          TX: begin
            if (tx_step) begin
              ser_out       <= ser_in;
              ser_out_valid <= 1'b1;
              if (tx_last) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                history    <= '0;
                state      <= IDLE;
              end
            end
          end
          default: begin
            state   <= IDLE;
            history <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
